// File: rtl/api_chip_resp_if.sv
// Serial link between the api controller (master) and a chip responder (slave).
// load frames a transfer; sck and mosi come from the controller; miso returns data.
interface api_chip_resp_if;
  logic load;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output load, output sck, output mosi, input miso);
  modport slave  (input load, input sck, input mosi, output miso);
endinterface

// File: rtl/api_chip_resp.sv
// Chip-side responder for the api serial link: captures one work frame per load window
// and returns a status word plus queued nonces on miso during the same window.
module api_chip_resp #(
  parameter int WORK_LEN    = 23,
  parameter int NONCE_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK_I,
  input  logic                     RST_N,
  api_chip_resp_if.slave           link,
  output logic [WORK_LEN*32-1:0]   work_data,
  output logic                     work_valid,
  input  logic                     nonce_push,
  input  logic [31:0]              nonce_din,
  output logic                     nonce_full,
  output logic                     nonce_drop,
  output logic                     frame_err
);

  localparam int FRAME_BITS = WORK_LEN * 32;
  localparam int OC_W       = $clog2(FRAME_BITS + 2);
  localparam int PTR_W      = (NONCE_DEPTH > 1) ? $clog2(NONCE_DEPTH) : 1;
  localparam int CNT_W      = $clog2(NONCE_DEPTH + 1);
  localparam logic [OC_W-1:0]  BITS_END = OC_W'(FRAME_BITS);
  localparam logic [OC_W-1:0]  BITS_SAT = OC_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NONCE_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic                    load_s, sck_s, mosi_s;
  logic                    load_d_reg, sck_d_reg;
  logic                    load_rise, load_fall, sck_rise, sck_fall;
  logic                    start_pend_reg;
  logic [OC_W-1:0]         bit_cnt_reg;
  logic [OC_W-1:0]         out_cnt_reg;
  logic [OC_W-1:0]         out_cnt_next;
  logic [7:0]              n_reg;
  logic [7:0]              n_snap;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0]   work_data_reg;
  logic                    work_valid_reg, frame_err_reg, nonce_drop_reg, miso_reg;
  logic                    miso_next;
  logic [31:0]             out_word;
  logic [15:0]             word_idx;
  logic [PTR_W-1:0]        q_idx;
  logic [31:0]             queue_mem [NONCE_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        pop_n;
  logic                    frame_good, push_ok;

  // Stage 0 samples the pins; the last stage feeds edge detection.
  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      sync_reg[0] <= {link.load, link.sck, link.mosi};
    end
  end

  assign {load_s, sck_s, mosi_s} = sync_reg[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_d_reg;
  assign load_fall = ~load_s & load_d_reg;
  assign sck_rise  = sck_s & ~sck_d_reg;
  assign sck_fall  = ~sck_s & sck_d_reg;

  assign n_snap = ({{(16-CNT_W){1'b0}}, count_reg} > 16'd255) ? 8'hFF : 8'(count_reg);

  assign frame_good = (state_reg == DONE) && (bit_cnt_reg == BITS_END);
  assign pop_n      = frame_good ? CNT_W'(n_reg) : '0;
  // A push landing on the pop cycle sees the room that the pop frees.
  assign push_ok    = nonce_push && ((count_reg - pop_n) != CNT_FULL);

  // Next miso bit: status word, then n queue entries by index, then zeros.
  always_comb begin
    out_cnt_next = (out_cnt_reg >= BITS_END) ? BITS_END : out_cnt_reg + OC_W'(1);
    word_idx     = 16'(out_cnt_next >> 5);
    q_idx        = rd_ptr_reg + PTR_W'(word_idx - 16'd1);
    out_word     = '0;
    if (out_cnt_next == BITS_END) begin
      out_word = '0;
    end else if (word_idx == 16'd0) begin
      out_word = {8'hA5, 16'h0000, n_reg};
    end else if (word_idx <= {8'h00, n_reg}) begin
      out_word = queue_mem[q_idx];
    end
    miso_next = out_word[5'd31 - out_cnt_next[4:0]];
  end

  always_ff @(posedge CLK_I) begin
    if (push_ok) begin
      queue_mem[wr_ptr_reg] <= nonce_din;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      load_d_reg     <= 1'b0;
      sck_d_reg      <= 1'b0;
      start_pend_reg <= 1'b0;
      bit_cnt_reg    <= '0;
      out_cnt_reg    <= '0;
      n_reg          <= '0;
      shift_reg      <= '0;
      work_data_reg  <= '0;
      work_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      nonce_drop_reg <= 1'b0;
      miso_reg       <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      load_d_reg     <= load_s;
      sck_d_reg      <= sck_s;
      work_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      nonce_drop_reg <= nonce_push && !push_ok;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      count_reg  <= count_reg + CNT_W'(push_ok) - pop_n;
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_n);

      case (state_reg)
        IDLE: begin
          miso_reg <= 1'b0;
          if (load_rise || start_pend_reg) begin
            start_pend_reg <= 1'b0;
            n_reg          <= n_snap;
            bit_cnt_reg    <= '0;
            out_cnt_reg    <= '0;
            miso_reg       <= 1'b1;  // status word MSB (0xA5)
            state_reg      <= SHIFT;
          end
        end
        SHIFT: begin
          if (load_fall) begin
            state_reg <= DONE;
          end else begin
            if (sck_rise) begin
              if (bit_cnt_reg < BITS_END) begin
                shift_reg   <= {shift_reg[FRAME_BITS-2:0], mosi_s};
                bit_cnt_reg <= bit_cnt_reg + OC_W'(1);
              end else begin
                bit_cnt_reg <= BITS_SAT;
              end
            end
            if (sck_fall) begin
              out_cnt_reg <= out_cnt_next;
              miso_reg    <= miso_next;
            end
          end
        end
        DONE: begin
          miso_reg <= 1'b0;
          if (load_rise) begin
            start_pend_reg <= 1'b1;
          end
          if (frame_good) begin
            work_data_reg  <= shift_reg;
            work_valid_reg <= 1'b1;
          end else begin
            frame_err_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign link.miso  = miso_reg;
  assign work_data  = work_data_reg;
  assign work_valid = work_valid_reg;
  assign nonce_full = (count_reg == CNT_FULL);
  assign nonce_drop = nonce_drop_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_api_chip_resp.sv
// Bench for api_chip_resp: drives the controller side of the link, models the nonce
// queue and scoreboards every received miso word and every work_data update.
module tb_api_chip_resp;
  localparam int WORK_LEN    = 23;
  localparam int NONCE_DEPTH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BITS  = WORK_LEN * 32;
  localparam int H           = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [FRAME_BITS-1:0] work_data;
  logic work_valid, nonce_push, nonce_full, nonce_drop, frame_err;
  logic [31:0] nonce_din;

  api_chip_resp_if s ();

  api_chip_resp #(
    .WORK_LEN(WORK_LEN), .NONCE_DEPTH(NONCE_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK_I(clk), .RST_N(rst_n), .link(s),
    .work_data(work_data), .work_valid(work_valid),
    .nonce_push(nonce_push), .nonce_din(nonce_din),
    .nonce_full(nonce_full), .nonce_drop(nonce_drop), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [FRAME_BITS-1:0] exp_work_q[$];
  logic [FRAME_BITS-1:0] last_work = '0;
  logic [31:0] tx_words [WORK_LEN];

  task automatic check(input string tag, input logic [FRAME_BITS-1:0] got,
                       input logic [FRAME_BITS-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (work_valid) begin
      wv_cnt++;
      if (exp_work_q.size() == 0) check("work_valid_unexp", work_valid, 1'b0);
      else check("work_data", work_data, exp_work_q.pop_front());
    end
    if (frame_err) fe_cnt++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_nonce(input logic [31:0] v);
    bit drop_exp;
    drop_exp = (model_q.size() >= NONCE_DEPTH);
    if (!drop_exp) model_q.push_back(v);
    nonce_push = 1'b1;
    nonce_din  = v;
    cyc(1);
    nonce_push = 1'b0;
    check("nonce_drop", nonce_drop, drop_exp);
    check("nonce_full", nonce_full, model_q.size() == NONCE_DEPTH);
    $display("[TB] push %08h drop=%0d", v, drop_exp);
  endtask

  task automatic set_words(input bit incr);
    for (int i = 0; i < WORK_LEN; i++)
      tx_words[i] = incr ? 32'(i + 1) : $urandom;
  endtask

  task automatic send_frame(input int nbits, input int abort_at,
                            input bit done_push, input logic [31:0] dp_val);
    int n, ncmp, lim, wv0, fe0;
    bit good;
    logic [31:0] rx;
    logic [FRAME_BITS-1:0] w_exp;
    lim  = (abort_at >= 0 && abort_at < nbits) ? abort_at : nbits;
    good = (abort_at < 0) && (nbits == FRAME_BITS);
    n    = model_q.size();
    ncmp = lim / 32;
    for (int w = 0; w < ncmp; w++) begin
      if (w == 0) exp_q.push_back({8'hA5, 16'h0000, 8'(n)});
      else if (w <= n) exp_q.push_back(model_q[w-1]);
      else exp_q.push_back(32'h0);
    end
    for (int i = 0; i < WORK_LEN; i++) w_exp[(WORK_LEN-1-i)*32 +: 32] = tx_words[i];
    if (good) exp_work_q.push_back(w_exp);
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    rx  = '0;
    s.sck = 1'b0; s.mosi = 1'b0; s.load = 1'b1;
    cyc(H);
    for (int b = 0; b < lim; b++) begin
      s.mosi = tx_words[b/32][31 - (b%32)];
      cyc(H);
      rx = {rx[30:0], s.miso};
      if ((b % 32) == 31) check($sformatf("miso_w%0d", b/32), rx, exp_q.pop_front());
      s.sck = 1'b1;
      cyc(H);
      s.sck = 1'b0;
    end
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #2;
      check("rst_miso", s.miso, 1'b0);
      check("rst_work_data", work_data, '0);
      check("rst_work_valid", work_valid, 1'b0);
      check("rst_nonce_full", nonce_full, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      s.load = 1'b0; s.mosi = 1'b0;
      model_q.delete();
      last_work = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(6);
      check("abort_work_valid", wv_cnt - wv0, 0);
      check("abort_frame_err", fe_cnt - fe0, 0);
      $display("[TB] frame aborted by reset at bit %0d", abort_at);
      return;
    end
    cyc(H);
    s.load = 1'b0;
    if (done_push) begin
      cyc(SYNC_STAGES + 1);
      nonce_push = 1'b1;
      nonce_din  = dp_val;
      cyc(1);
      nonce_push = 1'b0;
      check("done_push_drop", nonce_drop, 1'b0);
    end
    cyc(8);
    check("work_valid_cnt", wv_cnt - wv0, good ? 1 : 0);
    check("frame_err_cnt", fe_cnt - fe0, good ? 0 : 1);
    if (good) begin
      for (int i = 0; i < n; i++) void'(model_q.pop_front());
      last_work = w_exp;
    end else begin
      check("work_hold", work_data, last_work);
    end
    if (done_push) model_q.push_back(dp_val);
    check("post_nonce_full", nonce_full, model_q.size() == NONCE_DEPTH);
    $display("[TB] frame bits=%0d n=%0d good=%0d queue=%0d", lim, n, good, model_q.size());
  endtask

  initial begin
    s.load = 1'b0; s.sck = 1'b0; s.mosi = 1'b0;
    nonce_push = 1'b0; nonce_din = '0;
    cyc(3);
    check("reset_miso", s.miso, 1'b0);
    check("reset_work_data", work_data, '0);
    check("reset_work_valid", work_valid, 1'b0);
    check("reset_nonce_full", nonce_full, 1'b0);
    check("reset_nonce_drop", nonce_drop, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    cyc(3);

    // sck activity with load low must be ignored
    for (int i = 0; i < 10; i++) begin
      s.sck = ~s.sck;
      s.mosi = 1'($urandom);
      cyc(H);
      check("idle_miso", s.miso, 1'b0);
    end
    s.sck = 1'b0;
    cyc(4);
    check("idle_wv", wv_cnt, 0);
    check("idle_fe", fe_cnt, 0);
    check("idle_work_data", work_data, '0);

    set_words(1'b1);
    send_frame(FRAME_BITS, -1, 1'b0, '0);
    check("wd_first_word", work_data[FRAME_BITS-1 -: 32], 32'h00000001);
    check("wd_last_word", work_data[31:0], 32'h00000017);

    push_nonce(32'h11111111);
    push_nonce(32'h22222222);
    set_words(1'b0);
    send_frame(FRAME_BITS, -1, 1'b0, '0);

    push_nonce(32'hCAFEF00D);
    set_words(1'b0);
    send_frame(100, -1, 1'b0, '0);
    set_words(1'b0);
    send_frame(FRAME_BITS, -1, 1'b0, '0);

    for (int i = 1; i <= 5; i++) push_nonce(32'h10000000 + 32'(i));
    set_words(1'b0);
    send_frame(FRAME_BITS, -1, 1'b0, '0);

    for (int i = 1; i <= 4; i++) push_nonce(32'h20000000 + 32'(i));
    set_words(1'b0);
    send_frame(FRAME_BITS, -1, 1'b1, 32'hDEAD0001);
    set_words(1'b0);
    send_frame(FRAME_BITS, -1, 1'b0, '0);

    for (int i = 1; i <= 3; i++) push_nonce(32'h30000000 + 32'(i));
    set_words(1'b0);
    send_frame(FRAME_BITS, 300, 1'b0, '0);
    set_words(1'b1);
    send_frame(FRAME_BITS, -1, 1'b0, '0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_work_drained", 32'(exp_work_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
